icg_bank: RTL and testbench

- Parametrised multi-channel integrated clock-gate controller. Successor to the single-channel latch-based ICG cell.
- Each of NCH channels derives a glitch-free gated clock from one root clock.
- Each channel has an activity request, a programmable idle hold-off (hysteresis) and a per-channel force-on. A global test enable overrides all gating.
- Sits between the clock root and the functional sub-blocks of a power domain.

---
 rtl/icg_bank.sv | 110 +++++++++++
 tb/tb_icg_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/icg_bank.sv
// Multi-channel clock-gate controller: per-channel OFF/ON/DRAIN idle hold-off FSM
// feeding a latch-based glitch-free gate. Optional ICG_BANK_SOFTSTART_EN staggers wake-ups.
module icg_bank #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned HOLD_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TE,
    input  logic [NCH-1:0]    E,
    input  logic [NCH-1:0]    FORCE,
    input  logic [HOLD_W-1:0] HOLD,
    output logic [NCH-1:0]    Q,
    output logic [NCH-1:0]    EN_STAT,
    output logic              IDLE
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_DRAIN
    } state_t;

    state_t            state_q [NCH];
    state_t            state_d [NCH];
    logic [HOLD_W-1:0] cnt_q   [NCH];
    logic [HOLD_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]    en_q;
    logic [NCH-1:0]    en_d;
    logic [NCH-1:0]    lat_q;
    logic [NCH-1:0]    req;
`ifdef ICG_BANK_SOFTSTART_EN
    logic              wake_taken;
`endif

    always_comb begin
        req = E | FORCE;
`ifdef ICG_BANK_SOFTSTART_EN
        wake_taken = 1'b0;
`endif
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (req[i]) begin
`ifdef ICG_BANK_SOFTSTART_EN
                        // ascending scan: only the lowest-index waking channel is granted
                        if (!wake_taken) begin
                            state_d[i] = ST_ON;
                            wake_taken = 1'b1;
                        end
`else
                        state_d[i] = ST_ON;
`endif
                    end
                end
                ST_ON: begin
                    if (!req[i]) begin
                        if (HOLD == '0) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            state_d[i] = ST_DRAIN;
                            cnt_d[i]   = HOLD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (req[i]) begin
                        state_d[i] = ST_ON;
                    end else if (cnt_q[i] == HOLD_W'(1)) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] - HOLD_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    cnt_d[i]   = '0;
                end
            endcase
            if (RST) begin
                state_d[i] = ST_OFF;
                cnt_d[i]   = '0;
            end
            en_d[i] = (state_d[i] != ST_OFF);
        end
    end

    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
        end
        en_q <= en_d;
    end

    // Enable is captured only while CLK is low, so a high phase is never cut short.
    always_latch begin
        if (!CLK) begin
            lat_q <= en_q;
        end
    end

    assign Q       = {NCH{CLK}} & (lat_q | {NCH{TE}});
    assign EN_STAT = en_q;
    assign IDLE    = ~|en_q;

endmodule

// File: tb/tb_icg_bank.sv
// Randomised scoreboard bench for icg_bank: a hold-off reference model predicts EN_STAT/IDLE/Q
// per edge, a monitor pops and compares, and a pulse-width watcher flags runt Q pulses.
module tb_icg_bank;

    localparam int unsigned NCH    = 4;
    localparam int unsigned HOLD_W = 4;
    localparam int          HALF   = 5;

    logic              clk;
    logic              rst;
    logic              te;
    logic [NCH-1:0]    e;
    logic [NCH-1:0]    f;
    logic [HOLD_W-1:0] hold;
    logic [NCH-1:0]    q;
    logic [NCH-1:0]    en_stat;
    logic              idle;

    int n_checks = 0;
    int n_errors = 0;

    icg_bank #(.NCH(NCH), .HOLD_W(HOLD_W)) dut (
        .CLK    (clk),
        .RST    (rst),
        .TE     (te),
        .E      (e),
        .FORCE  (f),
        .HOLD   (hold),
        .Q      (q),
        .EN_STAT(en_stat),
        .IDLE   (idle)
    );

    initial clk = 1'b0;
    always #HALF clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    typedef struct {
        logic [NCH-1:0] en;
        logic           idle;
        logic [NCH-1:0] q;
        bit             qv;
    } exp_t;

    exp_t sb[$];

    // Reference model: a channel is enabled while requested, and stays enabled for
    // HOLD further edges (HOLD sampled at the first edge without request) after that.
    logic [NCH-1:0] m_en = '0;
    int             rem [NCH];
    bit             known = 1'b0;

    always @(posedge clk) begin
        exp_t           x;
        logic [NCH-1:0] nxt;
        bit             granted;
        x.q  = m_en | {NCH{te}};
        x.qv = known;
        nxt  = m_en;
        if (rst) begin
            nxt   = '0;
            known = 1'b1;
            for (int i = 0; i < NCH; i++) rem[i] = -1;
        end else if (known) begin
            granted = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (e[i] | f[i]) begin
                    if (!m_en[i]) begin
`ifdef ICG_BANK_SOFTSTART_EN
                        if (!granted) begin
                            nxt[i]  = 1'b1;
                            granted = 1'b1;
                        end
`else
                        nxt[i] = 1'b1;
`endif
                    end
                    rem[i] = -1;
                end else if (m_en[i]) begin
                    if (rem[i] < 0) rem[i] = int'(hold);
                    nxt[i] = (rem[i] > 0);
                    if (nxt[i]) rem[i]--;
                end
            end
        end
        m_en = nxt;
        if (known) begin
            x.en   = m_en;
            x.idle = (m_en == '0);
            sb.push_back(x);
        end
    end

    // Monitor: Q sampled inside the high phase, state outputs and Q-low in the low phase.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                if (x.qv) chk("q_high_phase", 32'(q), 32'(x.q));
                @(negedge clk);
                #1;
                chk("en_stat", 32'(en_stat), 32'(x.en));
                chk("idle", 32'(idle), 32'(x.idle));
                chk("q_low_phase", 32'(q), 32'(0));
            end
        end
    end

    // Every Q high pulse must last exactly one CLK high phase.
    bit             mon_en = 1'b0;
    logic [NCH-1:0] pq = 'x;
    time            rt [NCH];
    bit             rv [NCH];

    always @(q) begin
        for (int i = 0; i < NCH; i++) begin
            if (pq[i] === 1'b0 && q[i] === 1'b1) begin
                rt[i] = $time;
                rv[i] = 1'b1;
            end else if (pq[i] === 1'b1 && q[i] === 1'b0 && rv[i] && mon_en) begin
                chk("q_pulse_width", 32'($time - rt[i]), 32'(2 * HALF / 2));
            end
        end
        pq = q;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    initial begin
        rst  = 1'b1;
        te   = 1'b0;
        e    = '0;
        f    = '0;
        hold = '0;
        tick(2);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(1);

        // basic enable, HOLD=0
        e = 4'b0001; tick(3);
        e = '0;      tick(3);

        // hysteresis HOLD=3, then re-request while the count is at 1
        hold = 4'd3;
        e = 4'b0010; tick(1);
        e = '0;      tick(6);
        e = 4'b0010; tick(1);
        e = '0;      tick(3);
        e = 4'b0010; tick(1);
        e = '0;      tick(6);

        // maximum HOLD honoured without wrap
        hold = 4'hF;
        e = 4'b0001; tick(1);
        e = '0;      tick(20);

        // HOLD changed mid-drain does not affect the running count
        hold = 4'd5;
        e = 4'b0100; tick(1);
        e = '0;      tick(2);
        hold = 4'd1; tick(8);

        // test enable overrides gating, dropped in a low phase
        hold = '0;
        te = 1'b1; tick(4);
        te = 1'b0; tick(2);

        // FORCE keeps a channel running, then reset in the middle of a drain
        f = 4'b0100; tick(4);
        hold = 4'd5;
        e = 4'b1000; tick(1);
        e = '0;      tick(1);
        rst = 1'b1;  tick(1);
        rst = 1'b0;
        f = '0;      tick(3);

        // simultaneous wake of all channels
        hold = '0;
        e = 4'b1111; tick(5);
        e = '0;      tick(2);

        // randomised toggling in both clock phases
        for (int c = 0; c < 1000; c++) begin
            e = NCH'($urandom);
            if ($urandom_range(0, 7) == 0) f = NCH'($urandom) & NCH'($urandom);
            if ($urandom_range(0, 15) == 0) hold = HOLD_W'($urandom);
            if ($urandom_range(0, 31) == 0) te = ~te;
            rst = ($urandom_range(0, 63) == 0);
            @(posedge clk);
            #2;
            e = NCH'($urandom);
            tick(1);
        end
        rst = 1'b0;
        te  = 1'b0;
        e   = '0;
        f   = '0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
